// File: rtl/mult_bus_adapter.sv
// ============================================================================
// Module   : mult_bus_adapter
// Purpose  : Valid/ready front end that serialises an operand pair onto a
//            shared 6-bit Booth multiplier bus and reassembles the product.
//            Optional macro BOOTH_TIMEOUT_EN adds a WAIT timeout and err flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_bus_adapter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [5:0]  xIn,
    input  logic [5:0]  yIn,
    output logic        start,
    input  logic        done,
    output logic [5:0]  busOut,
    input  logic [5:0]  busIn,
    output logic        outValid,
    input  logic        outReady,
    output logic [11:0] product,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SENDX = 3'd1,
        SENDY = 3'd2,
        WAIT  = 3'd3,
        CAPLO = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t      r_state;
    logic [5:0]  r_y;
    logic        r_start;
    logic [5:0]  r_bus;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [11:0] r_product;

`ifdef BOOTH_TIMEOUT_EN
    logic [3:0]  r_cnt;
    logic        r_err;
`endif

    // Outputs are registered and updated together with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_y         <= 6'd0;
            r_start     <= 1'b0;
            r_bus       <= 6'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_product   <= 12'd0;
`ifdef BOOTH_TIMEOUT_EN
            r_cnt       <= 4'd0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (inValid) begin
                        r_y        <= yIn;
                        r_bus      <= xIn;
                        r_start    <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= SENDX;
                    end
                end
                SENDX: begin
                    r_start <= 1'b0;
                    r_bus   <= r_y;
                    r_state <= SENDY;
                end
                SENDY: begin
                    r_bus   <= 6'd0;
                    r_state <= WAIT;
`ifdef BOOTH_TIMEOUT_EN
                    r_cnt   <= 4'd0;
`endif
                end
                WAIT: begin
                    if (done) begin
                        r_product[11:6] <= busIn;
                        r_state         <= CAPLO;
                    end
`ifdef BOOTH_TIMEOUT_EN
                    else begin
                        r_cnt <= r_cnt + 4'd1;
                        // Counter reaching 15 without done abandons the operation.
                        if (r_cnt == 4'd14) begin
                            r_product   <= 12'd0;
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end
`endif
                end
                CAPLO: begin
                    r_product[5:0] <= busIn;
                    r_out_valid    <= 1'b1;
                    r_state        <= HOLD;
                end
                HOLD: begin
                    if (outReady) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
`ifdef BOOTH_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_start     <= 1'b0;
                    r_bus       <= 6'd0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign inReady  = r_in_ready;
    assign start    = r_start;
    assign busOut   = r_bus;
    assign outValid = r_out_valid;
    assign product  = r_product;

`ifdef BOOTH_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_bus_adapter.sv
// ============================================================================
// Module   : tb_mult_bus_adapter
// Purpose  : Self-checking bench for mult_bus_adapter; the bench plays the
//            Booth multiplier by driving done/busIn with hand-computed halves.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_bus_adapter;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [5:0]  xIn;
    logic [5:0]  yIn;
    logic        start;
    logic        done;
    logic [5:0]  busOut;
    logic [5:0]  busIn;
    logic        outValid;
    logic        outReady;
    logic [11:0] product;
    logic        err;

    int checks   = 0;
    int failures = 0;

    mult_bus_adapter dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .inReady  (inReady),
        .xIn      (xIn),
        .yIn      (yIn),
        .start    (start),
        .done     (done),
        .busOut   (busOut),
        .busIn    (busIn),
        .outValid (outValid),
        .outReady (outReady),
        .product  (product),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  x;
        logic [5:0]  y;
        logic [5:0]  hi;
        logic [5:0]  lo;
        int          waitc;
        int          holdc;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Handshake, then check the X and Y bus cycles; returns in the first WAIT cycle.
    task automatic send_pair(input logic [5:0] x, input logic [5:0] y);
        @(negedge clk);
        chk("idle_inReady", inReady, 12'd1);
        inValid = 1'b1;
        xIn     = x;
        yIn     = y;
        @(negedge clk);
        inValid = 1'b0;
        chk("sendx_start", start, 12'd1);
        chk("sendx_bus", busOut, x);
        chk("sendx_inReady", inReady, 12'd0);
        @(negedge clk);
        chk("sendy_start", start, 12'd0);
        chk("sendy_bus", busOut, y);
        @(negedge clk);
        chk("wait_bus", busOut, 12'd0);
        chk("wait_start", start, 12'd0);
    endtask

    task automatic finish_txn(input logic [5:0] hi, input logic [5:0] lo,
                              input int waitc, input int holdc, input logic [11:0] exp);
        repeat (waitc) @(negedge clk);
        chk("wait_outValid", outValid, 12'd0);
        done  = 1'b1;
        busIn = hi;
        @(negedge clk);
        done  = 1'b0;
        busIn = lo;
        chk("caplo_outValid", outValid, 12'd0);
        @(negedge clk);
        busIn = 6'd0;
        chk("hold_outValid", outValid, 12'd1);
        chk("hold_product", product, exp);
        chk("hold_inReady", inReady, 12'd0);
        for (int i = 0; i < holdc; i++) begin
            @(negedge clk);
            chk("bp_outValid", outValid, 12'd1);
            chk("bp_product", product, exp);
            chk("bp_inReady", inReady, 12'd0);
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        chk("ret_inReady", inReady, 12'd1);
        chk("ret_outValid", outValid, 12'd0);
        chk("ret_product", product, exp);
        chk("ret_err", err, 12'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // {x, y, hi, lo, wait cycles before done, extra HOLD cycles, product}
        vecs[0] = '{6'd3,  6'd5,  6'h00, 6'h0F, 5, 0, 12'd15};
        vecs[1] = '{6'h3E, 6'd7,  6'h3F, 6'h32, 2, 0, 12'hFF2};
        vecs[2] = '{6'h3D, 6'h3C, 6'h00, 6'h0C, 0, 5, 12'h00C};
        vecs[3] = '{6'd31, 6'd31, 6'h0F, 6'h01, 1, 1, 12'h3C1};
        vecs[4] = '{6'h20, 6'h20, 6'h10, 6'h00, 3, 0, 12'h400};
        vecs[5] = '{6'h20, 6'd31, 6'h30, 6'h20, 4, 2, 12'hC20};

        rst      = 1'b1;
        inValid  = 1'b0;
        xIn      = 6'd0;
        yIn      = 6'd0;
        done     = 1'b0;
        busIn    = 6'd0;
        outReady = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_inReady", inReady, 12'd1);
        chk("rst_start", start, 12'd0);
        chk("rst_busOut", busOut, 12'd0);
        chk("rst_outValid", outValid, 12'd0);
        chk("rst_product", product, 12'd0);
        chk("rst_err", err, 12'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            send_pair(vecs[v].x, vecs[v].y);
            finish_txn(vecs[v].hi, vecs[v].lo, vecs[v].waitc, vecs[v].holdc, vecs[v].exp);
        end

        // Reset in the middle of WAIT, then a late done that must be ignored.
        send_pair(6'd5, 6'd6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_inReady", inReady, 12'd1);
        chk("midrst_outValid", outValid, 12'd0);
        chk("midrst_product", product, 12'd0);
        chk("midrst_busOut", busOut, 12'd0);
        done  = 1'b1;
        busIn = 6'h3F;
        @(negedge clk);
        done  = 1'b0;
        @(negedge clk);
        busIn = 6'd0;
        chk("latedone_inReady", inReady, 12'd1);
        chk("latedone_outValid", outValid, 12'd0);
        chk("latedone_product", product, 12'd0);
        send_pair(6'd2, 6'd3);
        finish_txn(6'h00, 6'h06, 1, 0, 12'd6);

        // Spurious done in IDLE: no capture, no state change.
        done  = 1'b1;
        busIn = 6'h2A;
        @(negedge clk);
        done  = 1'b0;
        @(negedge clk);
        busIn = 6'd0;
        chk("spur_inReady", inReady, 12'd1);
        chk("spur_outValid", outValid, 12'd0);
        chk("spur_product", product, 12'd6);
        chk("spur_start", start, 12'd0);

`ifdef BOOTH_TIMEOUT_EN
        send_pair(6'd1, 6'd1);
        repeat (14) @(negedge clk);
        chk("to_early_outValid", outValid, 12'd0);
        @(negedge clk);
        chk("to_outValid", outValid, 12'd1);
        chk("to_err", err, 12'd1);
        chk("to_product", product, 12'd0);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        chk("to_err_clear", err, 12'd0);
        chk("to_inReady", inReady, 12'd1);
`else
        send_pair(6'd1, 6'd1);
        repeat (20) @(negedge clk);
        chk("notimeout_outValid", outValid, 12'd0);
        chk("notimeout_err", err, 12'd0);
        finish_txn(6'h00, 6'h01, 0, 0, 12'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
